instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch unit that consumes the program counter stream. It holds the architectural fetch PC, issues word reads to instruction memory over a valid/ready request channel, accepts in-order responses, and delivers {pc, instr} pairs to decode through a small buffer with valid/ready flow control. Decode/execute redirects it on branches and jumps; stale in-flight responses are discarded.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, fetch address after reset
- DEPTH, 2, fetch buffer entries = max outstanding + buffered instructions
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  load new fetch PC this cycle
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned read address
- imem_rsp_valid  in  1  read data valid (in order, ≥1 cycle after acceptance)
- imem_rsp_data  in  XLEN  instruction word
- if_valid  out  1  fetched instruction available
- if_ready  in  1  decode consumes
- if_pc  out  XLEN  PC of if_instr
- if_instr  out  XLEN  instruction word

## Operation
- States: FS_FETCH, FS_DRAIN. Reset state FS_FETCH.
- Reset (rst=1 at edge): fetch_pc=RESET_PC, outstanding=0, buffer empty, state FS_FETCH. Outputs during/after reset: imem_req_valid=0 while rst=1, imem_req_addr=fetch_pc, if_valid=0, if_pc=0, if_instr=0.
- FS_FETCH: imem_req_valid = (outstanding + buf_count < DEPTH). imem_req_addr = fetch_pc. On valid&ready: outstanding+1, fetch_pc += 4 (mod 2^XLEN; 32'hFFFF_FFFC wraps to 0).
- Response: imem_rsp_valid pushes {pc_of_oldest_outstanding, imem_rsp_data} into buffer, outstanding-1. Per-request PCs tracked in order (PC queue in buffer slot reserved at request time).
- Pop: if_valid & if_ready removes head. Push and pop in same cycle allowed at any occupancy.
- Redirect (FS_FETCH or FS_DRAIN): buffer flushed, fetch_pc = {redirect_pc[XLEN-1:2],2'b00}. Response arriving in the redirect cycle is discarded. Request accepted in the redirect cycle counts as stale. If stale outstanding after this cycle is 0 → FS_FETCH, else → FS_DRAIN.
- FS_DRAIN: imem_req_valid=0; every imem_rsp_valid discarded and decrements outstanding; outstanding reaching 0 → FS_FETCH next cycle. Further redirects update fetch_pc only.
- rst overrides redirect and all traffic in the same cycle.
- imem_rsp_valid with outstanding=0 is a protocol violation: assertion fires, response ignored.

## Timing
- Request combinational from registered state/counters; no combinational path imem_req_ready→imem_req_valid, nor if_ready→imem_req_valid.
- Response-to-if_valid latency: 1 cycle (registered buffer).
- First cycle with rst=0: imem_req_valid=1, addr=RESET_PC. With 1-cycle memory and if_ready=1: if_valid first at cycle 2 with if_pc=RESET_PC, then one instruction per cycle, PC +4 each.
- if_ready low: at most DEPTH instructions held; requests stop once buffer+outstanding = DEPTH; if_valid/if_pc/if_instr stable until popped.
- Redirect at edge N: if_valid=0 at N+1; first new request at N+1 if no stale outstanding.

## Structure
- Package fetch_pkg: XLEN, INSTR_BYTES=4, fetch_state_t {FS_FETCH, FS_DRAIN}, fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t with push/pop/flush, count, full/empty; reset and flush empty it.

## Test plan
- Reset release, 1-cycle memory, if_ready=1 -> addresses 0,4,8…; if_pc 0,4,8… one per cycle from cycle 2, if_instr matches memory.
- if_ready=0 for 10 cycles -> exactly 2 requests issued, if_valid held with if_pc=0, no loss or duplication on resume.
- Redirect to 32'h100 with 2 outstanding, responses at +1,+2 -> both discarded, FS_DRAIN 2 cycles, next if_pc=32'h100.
- Redirect to 32'h203 -> fetch at 32'h200; redirect coinciding with response -> response dropped.
- Fetch_pc 32'hFFFF_FFF8 -> next addresses 32'hFFFF_FFFC, 32'h0.
- rst asserted mid-stream with outstanding requests -> next cycle if_valid=0, imem_req_valid=0, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   XLEN          address / instruction width
//   INSTR_BYTES   byte size of one instruction word (fetch PC stride)
//   fetch_state_t FS_FETCH issues requests; FS_DRAIN discards stale responses
//   fetch_entry_t {pc, instr} pair handed to decode
package fetch_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [0:0] {
      FS_FETCH,
      FS_DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries between imem responses and decode.
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   flush           empties the FIFO; any push in the same cycle is lost
//   push, push_data write one entry (allowed when full only if popping too)
//   pop, head       head is the oldest entry; pop removes it (ignored when empty)
//   count           number of stored entries
//   full, empty     occupancy flags
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   output fetch_entry_t  head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  slots [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = slots[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: the storage array is deliberately not reset; count/pointers alone
   // define validity, and consumers mask head while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) slots[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks the fetch PC, issues word reads to instruction
// memory, buffers in-order responses and hands {pc, instr} to decode.
//   clk, rst                         clock, synchronous active-high reset
//   redirect_valid, redirect_pc      load a new fetch PC (low two bits dropped)
//   imem_req_valid/ready/addr        read request channel
//   imem_rsp_valid/data              in-order read responses
//   if_valid/ready, if_pc, if_instr  fetched instruction to decode
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = fetch_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 1;

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] fetch_pc_next;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_next;
   logic [CW-1:0]   buf_count;
   logic            credit_ok;
   logic            req_accept;
   logic            rsp_take;
   logic            buf_push;
   logic            buf_pop;
   logic            buf_empty;
   logic            unused_full;
   logic            unused_bits;
   fetch_entry_t    buf_in;
   fetch_entry_t    buf_head;

   assign unused_bits = ^redirect_pc[1:0];

   // Each outstanding request holds a buffer slot, so buffer overflow is
   // impossible. Built only from registered state: no ready-to-valid paths.
   assign credit_ok      = (SW'(outstanding) + SW'(buf_count)) < SW'(DEPTH);
   assign imem_req_valid = !rst && (state == FS_FETCH) && credit_ok;
   assign imem_req_addr  = fetch_pc;

   assign req_accept = imem_req_valid && imem_req_ready;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_take   = imem_rsp_valid && (outstanding != '0);
   assign buf_push   = rsp_take && (state == FS_FETCH) && !redirect_valid;
   assign buf_pop    = if_valid && if_ready;

   // Live requests are always a sequential run ending just below fetch_pc
   // (stale ones exist only in FS_DRAIN, where nothing is pushed), so the PC
   // of the oldest one is recovered arithmetically instead of queued.
   assign buf_in.pc    = fetch_pc - (XLEN'(outstanding) * XLEN'(INSTR_BYTES));
   assign buf_in.instr = imem_rsp_data;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (buf_push),
      .push_data (buf_in),
      .pop       (buf_pop),
      .head      (buf_head),
      .count     (buf_count),
      .full      (unused_full),
      .empty     (buf_empty)
   );

   assign if_valid = !buf_empty && !rst;
   assign if_pc    = if_valid ? buf_head.pc    : '0;
   assign if_instr = if_valid ? buf_head.instr : '0;

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_next       = state;
      fetch_pc_next    = fetch_pc;
      outstanding_next = outstanding + CW'(req_accept) - CW'(rsp_take);

      if (req_accept) fetch_pc_next = fetch_pc + XLEN'(INSTR_BYTES);

      // On redirect every request still in flight (including one accepted
      // this very cycle) is stale and must be drained before fetching again.
      if (redirect_valid) begin
         fetch_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
         state_next    = (outstanding_next == '0) ? FS_FETCH : FS_DRAIN;
      end else if ((state == FS_DRAIN) && (outstanding_next == '0)) begin
         state_next = FS_FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FS_FETCH;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
      end else begin
         state       <= state_next;
         fetch_pc    <= fetch_pc_next;
         outstanding <= outstanding_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(imem_rsp_valid && (outstanding == '0)))
            else $error("imem response received with no request outstanding");
      end
   end

endmodule
